// File: rtl/frame_pack_8_to_904_pkg.sv
// Shared constants for the 8-bit to 904-bit frame packer.
package frame_pack_8_to_904_pkg;

  localparam int unsigned FRAME_BYTES = 113;
  localparam int unsigned FRAME_W     = FRAME_BYTES * 8;
  localparam int unsigned IDX_W       = 7;

  localparam logic [7:0] SYNC0_DEF = 8'hEB;
  localparam logic [7:0] SYNC1_DEF = 8'h90;

  // Index of the checksum byte, the last byte of a frame.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  typedef logic [1:0] state_t;

  localparam state_t StHunt    = 2'd0;
  localparam state_t StSync    = 2'd1;
  localparam state_t StCollect = 2'd2;
  localparam state_t StEmit    = 2'd3;

endpackage

// File: rtl/frame_pack_8_to_904_idle_timer.sv
// Inter-byte idle timer: counts consecutive enabled cycles without a clear.
module idle_timer #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] cnt_q, cnt_d;

  // Fires on the TIMEOUT_CYC-th idle cycle; cnt_q holds idle cycles already elapsed.
  assign expired = enable && !clear && (cnt_q == TIMEOUT_CYC - 16'd1);

  // Next count: held at zero whenever disabled, cleared, or just expired.
  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!enable || clear || expired) begin
      cnt_d = '0;
    end
  end

  // Counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/frame_pack_8_to_904.sv
// Byte-stream frame packer: hunts for a two-byte sync, collects a 113-byte
// frame, verifies the trailing XOR checksum and pulses load for one cycle.
module frame_pack_8_to_904
  import frame_pack_8_to_904_pkg::*;
#(
  parameter logic [7:0]  SYNC0       = SYNC0_DEF,
  parameter logic [7:0]  SYNC1       = SYNC1_DEF,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1024
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [FRAME_W-1:0] frame,
  output logic               load,
  output logic               chk_err,
  output logic               tmo_err,
  output logic [15:0]        good_cnt
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         xor_q, xor_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               load_q, load_d;
  logic               chk_err_q, chk_err_d;
  logic               tmo_err_q, tmo_err_d;
  logic [15:0]        good_cnt_q, good_cnt_d;

  logic       xfer;
  logic       timer_en;
  logic       timer_expired;
  logic [9:0] bit_ofs;

  assign s_ready  = (state_q != StEmit);
  assign xfer     = s_valid && s_ready;
  assign timer_en = (state_q == StSync) || (state_q == StCollect);
  assign bit_ofs  = {idx_q, 3'b000};

  idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (xfer),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // Next-state logic for the framing FSM, frame store, checksum and status pulses.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    xor_d      = xor_q;
    frame_d    = frame_q;
    load_d     = 1'b0;
    chk_err_d  = 1'b0;
    tmo_err_d  = 1'b0;
    good_cnt_d = good_cnt_q;

    if (timer_expired) begin
      // Only possible without a transfer, so it never collides with load/chk_err.
      state_d   = StHunt;
      idx_d     = '0;
      xor_d     = '0;
      tmo_err_d = 1'b1;
    end else begin
      unique case (state_q)
        StHunt: begin
          if (xfer && (s_data == SYNC0)) begin
            frame_d[7:0] = s_data;
            xor_d        = s_data;
            state_d      = StSync;
          end
        end
        StSync: begin
          if (xfer) begin
            if (s_data == SYNC1) begin
              frame_d[15:8] = s_data;
              xor_d         = xor_q ^ s_data;
              idx_d         = IDX_W'(2);
              state_d       = StCollect;
            end else if (s_data == SYNC0) begin
              // A repeated SYNC0 restarts the frame on the newer byte.
              frame_d[7:0] = s_data;
              xor_d        = s_data;
            end else begin
              xor_d   = '0;
              state_d = StHunt;
            end
          end
        end
        StCollect: begin
          if (xfer) begin
            if (idx_q == LAST_IDX) begin
              idx_d = '0;
              xor_d = '0;
              if (s_data == xor_q) begin
                frame_d[bit_ofs +: 8] = s_data;
                load_d                = 1'b1;
                good_cnt_d            = good_cnt_q + 16'd1;
                state_d               = StEmit;
              end else begin
                chk_err_d = 1'b1;
                state_d   = StHunt;
              end
            end else begin
              frame_d[bit_ofs +: 8] = s_data;
              xor_d                 = xor_q ^ s_data;
              idx_d                 = idx_q + IDX_W'(1);
            end
          end
        end
        StEmit: begin
          // s_ready is low here, so frame holds steady for the load cycle.
          state_d = StHunt;
        end
        default: begin
          state_d = StHunt;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      idx_q      <= '0;
      xor_q      <= '0;
      frame_q    <= '0;
      load_q     <= 1'b0;
      chk_err_q  <= 1'b0;
      tmo_err_q  <= 1'b0;
      good_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      xor_q      <= xor_d;
      frame_q    <= frame_d;
      load_q     <= load_d;
      chk_err_q  <= chk_err_d;
      tmo_err_q  <= tmo_err_d;
      good_cnt_q <= good_cnt_d;
    end
  end

  assign frame    = frame_q;
  assign load     = load_q;
  assign chk_err  = chk_err_q;
  assign tmo_err  = tmo_err_q;
  assign good_cnt = good_cnt_q;

endmodule

// File: tb/tb_frame_pack_8_to_904.sv
// Directed bench for frame_pack_8_to_904 with a scoreboard of expected pulses.
module tb_frame_pack_8_to_904;

  localparam int unsigned FW = 904;

  logic          clk;
  logic          rst_n;
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic [FW-1:0] frame;
  logic          load;
  logic          chk_err;
  logic          tmo_err;
  logic [15:0]   good_cnt;

  frame_pack_8_to_904 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .frame    (frame),
    .load     (load),
    .chk_err  (chk_err),
    .tmo_err  (tmo_err),
    .good_cnt (good_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]    kind;  // 1 load, 2 chk_err, 3 tmo_err
    logic [15:0]   cnt;
    logic [FW-1:0] frm;
  } exp_t;

  exp_t          sb[$];
  int            checks = 0;
  int            errors = 0;
  int            low_cycles = 0;
  logic [7:0]    fb [0:112];
  logic [FW-1:0] exp_frame;
  logic [15:0]   exp_good = 16'd0;

  task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame: sync bytes, payload 00..6D, XOR checksum.
  task automatic build_frame();
    logic [7:0] x;
    fb[0] = 8'hEB;
    fb[1] = 8'h90;
    for (int i = 2; i < 112; i++) fb[i] = 8'(i - 2);
    x = 8'h00;
    for (int i = 0; i < 112; i++) x = x ^ fb[i];
    fb[112] = x;
    for (int i = 0; i < 113; i++) exp_frame[i*8 +: 8] = fb[i];
  endtask

  // Offer one byte and return just after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int guard;
    s_data  = b;
    s_valid = 1'b1;
    guard   = 0;
    while (!s_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 100) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: s_ready stayed %b, required 1", s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  // Send fb[lo..112], optionally corrupting the checksum, and check pulse latency.
  task automatic send_frame(input int lo, input bit flip, input bit keep_valid);
    exp_t e;
    for (int i = lo; i < 112; i++) send_byte(fb[i]);
    if (!flip) exp_good = exp_good + 16'd1;
    e.kind = flip ? 2'd2 : 2'd1;
    e.cnt  = exp_good;
    e.frm  = exp_frame;
    sb.push_back(e);
    send_byte(flip ? (fb[112] ^ 8'h01) : fb[112]);
    if (!keep_valid) s_valid = 1'b0;
    check("load_latency", FW'(load), FW'(!flip));
    check("chk_latency", FW'(chk_err), FW'(flip));
  endtask

  // Scoreboard monitor, sampled mid-cycle.
  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] kind_obs;
    if (rst_n) begin
      if (!s_ready) low_cycles++;
      if (load || chk_err || tmo_err) begin
        check("pulse_excl", FW'(int'(load) + int'(chk_err) + int'(tmo_err)), FW'(1));
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $error("FAIL unexpected_pulse: load=%b chk_err=%b tmo_err=%b, required none",
                 load, chk_err, tmo_err);
        end else begin
          e        = sb.pop_front();
          kind_obs = load ? 2'd1 : (chk_err ? 2'd2 : 2'd3);
          check("pulse_kind", FW'(kind_obs), FW'(e.kind));
          check("pulse_good_cnt", FW'(good_cnt), FW'(e.cnt));
          if (e.kind == 2'd1) check("pulse_frame", frame, e.frm);
        end
      end
    end
  end

  task automatic do_reset();
    rst_n   = 1'b0;
    s_valid = 1'b0;
    #1;
    check("rst_s_ready", FW'(s_ready), FW'(1));
    check("rst_good_cnt", FW'(good_cnt), FW'(0));
    check("rst_frame", frame, FW'(0));
    check("rst_pulses", FW'({load, chk_err, tmo_err}), FW'(0));
    repeat (3) @(posedge clk);
    #1;
    rst_n    = 1'b1;
    exp_good = 16'd0;
  endtask

  initial begin
    int low_before;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    build_frame();
    @(posedge clk);
    #1;
    do_reset();
    repeat (2) @(posedge clk);
    #1;

    // Valid frame, back-to-back.
    send_frame(0, 1'b0, 1'b0);
    check("t1_byte0", FW'(frame[7:0]), FW'(8'hEB));
    check("t1_byte1", FW'(frame[15:8]), FW'(8'h90));
    check("t1_good_cnt", FW'(good_cnt), FW'(1));
    repeat (3) @(posedge clk);
    #1;

    // Corrupted checksum.
    send_frame(0, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t2_good_cnt", FW'(good_cnt), FW'(1));

    // Junk and a repeated SYNC0 before the frame.
    send_byte(8'h12);
    send_byte(8'hEB);
    send_frame(0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t3_good_cnt", FW'(good_cnt), FW'(2));

    // Stall after byte 50 until the timeout fires.
    for (int i = 0; i <= 50; i++) send_byte(fb[i]);
    s_valid = 1'b0;
    sb.push_back('{kind: 2'd3, cnt: exp_good, frm: '0});
    repeat (1023) @(posedge clk);
    #1;
    check("t4_tmo_early", FW'(tmo_err), FW'(0));
    @(posedge clk);
    #1;
    check("t4_tmo_pulse", FW'(tmo_err), FW'(1));
    @(posedge clk);
    #1;
    check("t4_tmo_once", FW'(tmo_err), FW'(0));
    send_frame(0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t4_good_cnt", FW'(good_cnt), FW'(3));

    // Reset in the middle of a frame.
    for (int i = 0; i < 60; i++) send_byte(fb[i]);
    do_reset();
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_pulse", FW'({load, chk_err, tmo_err}), FW'(0));
    send_frame(0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_good_cnt", FW'(good_cnt), FW'(1));

    // Two frames with s_valid held high throughout.
    do_reset();
    @(posedge clk);
    #1;
    low_before = low_cycles;
    send_frame(0, 1'b0, 1'b1);
    send_frame(0, 1'b0, 1'b1);
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t6_ready_low", FW'(low_cycles - low_before), FW'(2));
    check("t6_good_cnt", FW'(good_cnt), FW'(2));

    check("sb_empty", FW'(sb.size()), FW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
